// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory responder and its write-posting FIFO.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DATA_W = 32;

    // Default layout of one posted write.
    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RD   = 2'd1,
        ACC_WR   = 2'd2
    } acc_e;

    // OEN low wins over WEN low, so a cycle is never both a read and a write.
    function automatic acc_e decode_access(input logic cen, input logic oen, input logic wen);
        acc_e acc;
        acc = ACC_NONE;
        if (cen && !oen) begin
            acc = ACC_RD;
        end else if (cen && !wen) begin
            acc = ACC_WR;
        end
        return acc;
    endfunction

endpackage

// File: rtl/dmem_responder_wbuf.sv
// Posted-write FIFO with a youngest-match forwarding lookup across all valid entries.
// Zero-latency lookup; the caller guarantees a push into a full FIFO always coincides with a pop.
module wbuf_fifo #(
    parameter  int ADDR_W = 7,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CNT_W-1:0]  o_count,
    input  logic [ADDR_W-1:0] i_look_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_hit_data
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic [PTR_W-1:0] w_idx;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            if (i_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!i_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage is not reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (rst_n && i_push) begin
            r_mem[r_tail] <= '{addr: i_push_addr, data: i_push_data};
        end
    end

    assign o_head_addr = r_mem[r_head].addr;
    assign o_head_data = r_mem[r_head].data;
    assign o_count     = r_count;

    // Scan oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_mem[w_idx].addr == i_look_addr)) begin
                o_hit      = 1'b1;
                o_hit_data = r_mem[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: same-cycle loads with forwarding, stores posted through wbuf_fifo.
// Array writes drain one FIFO entry in every non-read cycle; reads never stall.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter  int ADDR_W     = DMEM_ADDR_W,
    parameter  int DATA_W     = DMEM_DATA_W,
    parameter  int WBUF_DEPTH = 4,
    localparam int CNT_W      = $clog2(WBUF_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              OEN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    input  logic              flush,
    output logic [CNT_W-1:0]  wbuf_count,
    output logic              idle
);

    acc_e              w_acc;
    logic              w_rd;
    logic              w_wr;
    logic              w_pop;
    logic              w_hit;
    logic              w_flush_hold;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [DATA_W-1:0] w_hit_data;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    assign w_acc = decode_access(CEN, OEN, WEN);
    assign w_rd  = (w_acc == ACC_RD);
    assign w_wr  = (w_acc == ACC_WR);

    // The single array port belongs to the drain whenever no load needs it.
    assign w_pop = !w_rd && (w_count != '0);

    wbuf_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_wr),
        .i_push_addr (A),
        .i_push_data (Data2Mem),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .i_look_addr (A),
        .o_hit       (w_hit),
        .o_hit_data  (w_hit_data)
    );

    always_ff @(posedge clk) begin
        if (rst_n && w_pop) begin
            r_mem[w_head_addr] <= w_head_data;
        end
    end

    always_comb begin
        ReadDataMem = '0;
        if (rst_n && w_rd) begin
            ReadDataMem = w_hit ? w_hit_data : r_mem[A];
        end
    end

    // A flush request keeps idle low while entries remain, which coincides with a non-zero count.
    assign w_flush_hold = flush && (w_count != '0);
    assign idle         = (w_count == '0) && !w_flush_hold;
    assign wbuf_count   = w_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a reference memory plus posted-write queue predicts every read,
// expectations are queued as stimulus is driven and popped when the read data is sampled.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CEN, OEN, WEN, flush, idle;
    logic [6:0]  A;
    logic [31:0] Data2Mem, ReadDataMem;
    logic [2:0]  wbuf_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] m_arr [128];
    wbuf_entry_t m_wq  [$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(7), .DATA_W(32), .WBUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CEN         (CEN),
        .OEN         (OEN),
        .WEN         (WEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem),
        .flush       (flush),
        .wbuf_count  (wbuf_count),
        .idle        (idle)
    );

    function automatic logic [31:0] model_read(input logic [6:0] a);
        logic [31:0] v;
        v = m_arr[a];
        foreach (m_wq[i]) if (m_wq[i].addr == a) v = m_wq[i].data;
        return v;
    endfunction

    // Apply one cycle of inputs and queue the read data this cycle must show.
    task automatic drive(input logic cen, input logic oen, input logic wen,
                         input logic [6:0] a, input logic [31:0] d);
        CEN = cen; OEN = oen; WEN = wen; A = a; Data2Mem = d;
        if (rst_n && cen && !oen) exp_q.push_back(model_read(a));
        else                      exp_q.push_back(32'h0);
        #1;
    endtask

    // Advance one clock edge and update the reference state for that edge.
    task automatic tick();
        logic rd, wr;
        rd = CEN & ~OEN;
        wr = CEN & OEN & ~WEN;
        @(posedge clk);
        if (!rst_n) begin
            m_wq.delete();
        end else begin
            if (!rd && m_wq.size() > 0) begin
                m_arr[m_wq[0].addr] = m_wq[0].data;
                m_wq.delete(0);
            end
            if (wr) m_wq.push_back('{addr: A, data: Data2Mem});
        end
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 7'd3, 32'h0);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", ReadDataMem, e); end
        tick(); tick();
        total++; if (wbuf_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", wbuf_count); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        drive(1'b1, 1'b1, 1'b0, 7'd5, 32'hDEADBEEF);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t1_wr_rdata got=%h exp=%h", ReadDataMem, e); end
        tick();
        total++; if (wbuf_count !== 3'd1) begin bad++; $display("FAIL t1_count_after_wr got=%0d exp=1", wbuf_count); end
        drive(1'b1, 1'b0, 1'b1, 7'd5, 32'h0);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t1_fwd got=%h exp=%h", ReadDataMem, e); end
        total++; if (ReadDataMem !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_fwd_lit got=%h exp=deadbeef", ReadDataMem); end
        tick();
        total++; if (wbuf_count !== 3'd1) begin bad++; $display("FAIL t1_count_after_rd got=%0d exp=1", wbuf_count); end
        flush = 1'b1;
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL t1_idle_pending got=%b exp=0", idle); end
        drive(1'b0, 1'b1, 1'b1, 7'd0, 32'h0);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t1_idle_rdata got=%h exp=%h", ReadDataMem, e); end
        tick();
        total++; if (wbuf_count !== 3'd0) begin bad++; $display("FAIL t1_count_drained got=%0d exp=0", wbuf_count); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL t1_idle_drained got=%b exp=1", idle); end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        int ra [6] = '{1, 2, 3, 4, 4, 1};
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 7'(k), 32'h11 * k);
            e = exp_q.pop_front();
            total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t2_wr_rdata got=%h exp=%h", ReadDataMem, e); end
            tick();
        end
        total++; if (wbuf_count !== 3'd1) begin bad++; $display("FAIL t2_count_after_wr got=%0d exp=1", wbuf_count); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, 7'(ra[i]), 32'h0);
            e = exp_q.pop_front();
            total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t2_rd a=%0d got=%h exp=%h", ra[i], ReadDataMem, e); end
            tick();
        end
        total++; if (wbuf_count !== 3'd1) begin bad++; $display("FAIL t2_count_after_rd got=%0d exp=1", wbuf_count); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL t2_idle got=%b exp=0", idle); end
        drive(1'b0, 1'b1, 1'b1, 7'd0, 32'h0);
        void'(exp_q.pop_front());
        tick();
        total++; if (wbuf_count !== 3'd0) begin bad++; $display("FAIL t2_count_drained got=%0d exp=0", wbuf_count); end
    endtask

    task automatic test_overwrite();
        logic [31:0] e;
        drive(1'b1, 1'b1, 1'b0, 7'd0, 32'h5A5A0000); void'(exp_q.pop_front()); tick();
        drive(1'b0, 1'b1, 1'b1, 7'd0, 32'h0);        void'(exp_q.pop_front()); tick();
        drive(1'b1, 1'b1, 1'b0, 7'd9, 32'h1);
        e = exp_q.pop_front(); tick();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t3_wr1 got=%h exp=%h", ReadDataMem, e); end
        drive(1'b1, 1'b0, 1'b1, 7'd0, 32'h0);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t3_rd0 got=%h exp=%h", ReadDataMem, e); end
        tick();
        drive(1'b1, 1'b1, 1'b0, 7'd9, 32'h2); void'(exp_q.pop_front()); tick();
        drive(1'b1, 1'b0, 1'b1, 7'd9, 32'h0);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t3_rd9_fwd got=%h exp=%h", ReadDataMem, e); end
        total++; if (ReadDataMem !== 32'h2) begin bad++; $display("FAIL t3_rd9_fwd_lit got=%h exp=2", ReadDataMem); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 7'd0, 32'h0); void'(exp_q.pop_front()); tick();
        end
        total++; if (wbuf_count !== 3'd0) begin bad++; $display("FAIL t3_count_drained got=%0d exp=0", wbuf_count); end
        drive(1'b1, 1'b0, 1'b1, 7'd9, 32'h0);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== 32'h2) begin bad++; $display("FAIL t3_rd9_array got=%h exp=2", ReadDataMem); end
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t3_rd9_model got=%h exp=%h", ReadDataMem, e); end
        tick();
    endtask

    task automatic test_full();
        logic [31:0] e;
        int          n;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, 1'b0, 7'(20 + i), 32'hF0 + i); void'(exp_q.pop_front()); tick();
            drive(1'b1, 1'b0, 1'b1, 7'(20 + i), 32'h0);
            e = exp_q.pop_front();
            total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t4_fill_rd got=%h exp=%h", ReadDataMem, e); end
            tick();
            n = m_wq.size();
            total++; if (int'(wbuf_count) != n || n > DEPTH) begin bad++; $display("FAIL t4_fill_count got=%0d exp=%0d", wbuf_count, n); end
        end
        drive(1'b1, 1'b1, 1'b0, 7'd7, 32'hABCD); void'(exp_q.pop_front()); tick();
        n = m_wq.size();
        total++; if (int'(wbuf_count) != n) begin bad++; $display("FAIL t4_count_after_wr got=%0d exp=%0d", wbuf_count, n); end
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b1, 7'd0, 32'h0); void'(exp_q.pop_front()); tick();
        end
        total++; if (wbuf_count !== 3'd0) begin bad++; $display("FAIL t4_count_drained got=%0d exp=0", wbuf_count); end
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b1, (i == DEPTH) ? 7'd7 : 7'(20 + i), 32'h0);
            e = exp_q.pop_front();
            total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t4_array a=%0d got=%h exp=%h", A, ReadDataMem, e); end
            tick();
        end
    endtask

    task automatic test_decode();
        logic [31:0] e;
        drive(1'b1, 1'b1, 1'b0, 7'd3, 32'h3333); void'(exp_q.pop_front()); tick();
        drive(1'b0, 1'b1, 1'b1, 7'd0, 32'h0);    void'(exp_q.pop_front()); tick();
        drive(1'b1, 1'b0, 1'b0, 7'd3, 32'hFFFFFFFF);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t5_prio_rd got=%h exp=%h", ReadDataMem, e); end
        tick();
        total++; if (wbuf_count !== 3'd0) begin bad++; $display("FAIL t5_prio_nopush got=%0d exp=0", wbuf_count); end
        drive(1'b0, 1'b0, 1'b0, 7'd3, 32'hEEEEEEEE);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t5_cen0_rdata got=%h exp=%h", ReadDataMem, e); end
        tick();
        total++; if (wbuf_count !== 3'd0) begin bad++; $display("FAIL t5_cen0_nopush got=%0d exp=0", wbuf_count); end
        drive(1'b1, 1'b0, 1'b1, 7'd3, 32'h0);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== 32'h3333) begin bad++; $display("FAIL t5_array_kept got=%h exp=3333", ReadDataMem); end
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t5_array_model got=%h exp=%h", ReadDataMem, e); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 7'(40 + i), 32'hA0 + i); void'(exp_q.pop_front()); tick();
        end
        drive(1'b0, 1'b1, 1'b1, 7'd0, 32'h0); void'(exp_q.pop_front()); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 7'(40 + i), 32'hB0 + i); void'(exp_q.pop_front()); tick();
        end
        total++; if (wbuf_count === 3'd0) begin bad++; $display("FAIL t6_pending got=%0d exp=nonzero", wbuf_count); end
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 7'd42, 32'h0);
        e = exp_q.pop_front();
        total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t6_rst_rdata got=%h exp=%h", ReadDataMem, e); end
        tick();
        rst_n = 1'b1;
        total++; if (wbuf_count !== 3'd0) begin bad++; $display("FAIL t6_rst_count got=%0d exp=0", wbuf_count); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL t6_rst_idle got=%b exp=1", idle); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 7'(40 + i), 32'h0);
            e = exp_q.pop_front();
            total++; if (ReadDataMem !== e) begin bad++; $display("FAIL t6_array a=%0d got=%h exp=%h", 40 + i, ReadDataMem, e); end
            if (i == 2) begin
                total++; if (ReadDataMem !== 32'hA2) begin bad++; $display("FAIL t6_lost_write got=%h exp=a2", ReadDataMem); end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        CEN = 1'b0; OEN = 1'b1; WEN = 1'b1; A = '0; Data2Mem = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_overwrite();
        test_full();
        test_decode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
